// File: rtl/cla4_core.sv
`default_nettype none
// ============================================================================
// Module      : cla4_core
// Description : 4-bit carry-lookahead adder slice with registered sum, carry,
//               group propagate/generate and signed-overflow outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cla4_core (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       pg,
   output logic       gg,
   output logic       ov
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [4:0] w_c;
   logic [3:0] w_s;
   logic       w_pg;
   logic       w_gg;
   logic       w_ov;

   logic [3:0] r_s;
   logic       r_co;
   logic       r_pg;
   logic       r_gg;
   logic       r_ov;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Each carry is a flat sum of products so no bit waits on its neighbour.
   assign w_c[0] = ci;
   assign w_c[1] = w_g[0]
                 | (w_p[0] & ci);
   assign w_c[2] = w_g[1]
                 | (w_p[1] & w_g[0])
                 | (w_p[1] & w_p[0] & ci);
   assign w_c[3] = w_g[2]
                 | (w_p[2] & w_g[1])
                 | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & ci);
   assign w_c[4] = w_g[3]
                 | (w_p[3] & w_g[2])
                 | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

   assign w_s  = w_p ^ w_c[3:0];
   assign w_pg = &w_p;
   assign w_gg = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign w_ov = w_c[4] ^ w_c[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s  <= 4'd0;
         r_co <= 1'b0;
         r_pg <= 1'b0;
         r_gg <= 1'b0;
         r_ov <= 1'b0;
      end else begin
         r_s  <= w_s;
         r_co <= w_c[4];
         r_pg <= w_pg;
         r_gg <= w_gg;
         r_ov <= w_ov;
      end
   end

   assign s  = r_s;
   assign co = r_co;
   assign pg = r_pg;
   assign gg = r_gg;
   assign ov = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_cla4_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla4_core
// Description : Directed and exhaustive self-checking bench for cla4_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla4_core;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       ci;
   logic [3:0] s;
   logic       co;
   logic       pg;
   logic       gg;
   logic       ov;

   int r_checks;
   int r_fails;

   cla4_core u_dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .ci  (ci),
      .s   (s),
      .co  (co),
      .pg  (pg),
      .gg  (gg),
      .ov  (ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed observation: {co, s[3:0], pg, gg, ov}
   function automatic logic [7:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                        input logic mci);
      logic [4:0] sum;
      logic [4:0] gsum;
      logic       mov;
      logic       mpg;
      sum  = {1'b0, ma} + {1'b0, mb} + {4'd0, mci};
      gsum = {1'b0, ma} + {1'b0, mb};
      mov  = (ma[3] == mb[3]) && (sum[3] != ma[3]);
      mpg  = ((ma ^ mb) == 4'hF);
      return {sum[4], sum[3:0], mpg, gsum[4], mov};
   endfunction

   task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      r_checks++;
      if (obs !== exp) begin
         r_fails++;
         $display("FAIL %s observed=%b required=%b", tag, obs, exp);
      end
   endtask

   // Apply one vector, let one edge capture it, then sample away from the edge.
   task automatic step(input logic vr, input logic [3:0] va, input logic [3:0] vb,
                       input logic vci);
      rst = vr;
      a   = va;
      b   = vb;
      ci  = vci;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      tag;
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      logic [7:0] exp;   // {co, s, pg, gg, ov}
   } vec_t;

   vec_t dir_tbl[11];
   logic [7:0] r_exp;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      r_checks = 0;
      r_fails  = 0;

      dir_tbl[0]  = '{"zero",    4'h0, 4'h0, 1'b0, 8'b0_0000_000};
      dir_tbl[1]  = '{"2+4+0",   4'h2, 4'h4, 1'b0, 8'b0_0110_000};
      dir_tbl[2]  = '{"4+4+0",   4'h4, 4'h4, 1'b0, 8'b0_1000_001};
      dir_tbl[3]  = '{"A+1+1",   4'hA, 4'h1, 1'b1, 8'b0_1100_000};
      dir_tbl[4]  = '{"3+A+1",   4'h3, 4'hA, 1'b1, 8'b0_1110_000};
      dir_tbl[5]  = '{"1+B+1",   4'h1, 4'hB, 1'b1, 8'b0_1101_000};
      dir_tbl[6]  = '{"F+F+0",   4'hF, 4'hF, 1'b0, 8'b1_1110_010};
      dir_tbl[7]  = '{"8+8+0",   4'h8, 4'h8, 1'b0, 8'b1_0000_011};
      dir_tbl[8]  = '{"F+8+1",   4'hF, 4'h8, 1'b1, 8'b1_1000_010};
      dir_tbl[9]  = '{"6+9+0",   4'h6, 4'h9, 1'b0, 8'b0_1111_100};
      dir_tbl[10] = '{"6+9+1",   4'h6, 4'h9, 1'b1, 8'b1_0000_100};

      rst = 1'b1;
      a   = 4'h0;
      b   = 4'h0;
      ci  = 1'b0;
      @(negedge clk);

      step(1'b1, 4'hF, 4'hF, 1'b1);
      chk_eq("reset_cycle1", {co, s, pg, gg, ov}, 8'h00);
      step(1'b1, 4'hF, 4'hF, 1'b1);
      chk_eq("reset_cycle2", {co, s, pg, gg, ov}, 8'h00);

      foreach (dir_tbl[i]) begin
         step(1'b0, dir_tbl[i].a, dir_tbl[i].b, dir_tbl[i].ci);
         chk_eq(dir_tbl[i].tag, {co, s, pg, gg, ov}, dir_tbl[i].exp);
      end

      // Back-to-back stream with a single reset pulse on the third edge.
      step(1'b0, 4'h7, 4'h7, 1'b1);
      chk_eq("stream0", {co, s, pg, gg, ov}, 8'b0_1111_001);
      step(1'b0, 4'hC, 4'h5, 1'b0);
      chk_eq("stream1", {co, s, pg, gg, ov}, 8'b1_0001_010);
      step(1'b1, 4'hE, 4'h3, 1'b1);
      chk_eq("stream_rst", {co, s, pg, gg, ov}, 8'h00);
      step(1'b0, 4'h9, 4'h6, 1'b1);
      chk_eq("stream3", {co, s, pg, gg, ov}, 8'b1_0000_100);
      step(1'b0, 4'h5, 4'h2, 1'b0);
      chk_eq("stream4", {co, s, pg, gg, ov}, 8'b0_0111_000);

      for (int i = 0; i < 512; i++) begin
         logic [8:0] iv;
         iv = i[8:0];
         r_exp = model(iv[3:0], iv[7:4], iv[8]);
         step(1'b0, iv[3:0], iv[7:4], iv[8]);
         chk_eq($sformatf("sweep_%0h_%0h_%0d", iv[3:0], iv[7:4], iv[8]),
                {co, s, pg, gg, ov}, r_exp);
         chk_eq($sformatf("invariant_%0h_%0h_%0d", iv[3:0], iv[7:4], iv[8]),
                {7'd0, co}, {7'd0, r_exp[1] | (r_exp[2] & iv[8])});
      end

      $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
      $finish;
   end

endmodule
`default_nettype wire
